// File: rtl/hs_npu_requantizer.sv
`default_nettype none
// ============================================================================
//  Module   : hs_npu_requantizer
//  Purpose  : Post-accumulator output stage. Requantizes the int32 accumulator
//             stream to int8 (scale multiply, round-half-up arithmetic shift,
//             zero-point add, saturate). Results are buffered in a small FIFO
//             behind a valid/ready interface. The upstream cannot be stalled,
//             so FIFO overflow drops the sample and sets a sticky flag.
//  Options  : HS_NPU_REQUANT_RELU_EN - when defined, cfg_relu is registered
//             and negative inputs are clamped to zero before the multiply.
//  Revision : 1.0 - initial release
// ============================================================================
module hs_npu_requantizer #(
  parameter int IN_WIDTH    = 32,
  parameter int SCALE_WIDTH = 16,
  parameter int OUT_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic                   in_valid,
  input  logic                   cfg_en,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  input  logic [4:0]             cfg_shift,
  input  logic [OUT_WIDTH-1:0]   cfg_zp,
  input  logic                   cfg_relu,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   ovf,
  input  logic                   ovf_clr,
  output logic                   busy
);

  // Product width is exact for a signed x signed multiply; VW leaves headroom
  // for the rounding add and the zero-point add so nothing can wrap.
  localparam int PW = IN_WIDTH + SCALE_WIDTH;
  localparam int VW = PW + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // Configuration registers
  logic [SCALE_WIDTH-1:0] scale_q;
  logic [4:0]             shift_q;
  logic [OUT_WIDTH-1:0]   zp_q;

  // Pipeline registers
  logic                   s1_valid;
  logic [PW-1:0]          s1_prod;
  logic [4:0]             s1_shift;
  logic [OUT_WIDTH-1:0]   s1_zp;
  logic                   s2_valid;
  logic [OUT_WIDTH-1:0]   s2_data;

  // FIFO state
  logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;

  // Combinational datapath
  logic [IN_WIDTH-1:0]    opnd;
  logic signed [PW-1:0]   opnd_ext;
  logic signed [PW-1:0]   scale_ext;
  logic signed [PW-1:0]   prod;
  logic [PW:0]            rnd;
  logic signed [PW:0]     rsum;
  logic signed [PW:0]     rshift;
  logic [VW-1:0]          v;
  logic [VW-OUT_WIDTH:0]  v_top;
  logic [OUT_WIDTH-1:0]   sat_val;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   drop;

  // Configuration load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_q <= '0;
      shift_q <= '0;
      zp_q    <= '0;
    end else if (cfg_en) begin
      scale_q <= cfg_scale;
      shift_q <= cfg_shift;
      zp_q    <= cfg_zp;
    end
  end

`ifdef HS_NPU_REQUANT_RELU_EN
  logic relu_q;

  // ReLU enable register, loaded alongside the other configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relu_q <= 1'b0;
    end else if (cfg_en) begin
      relu_q <= cfg_relu;
    end
  end

  // Clamp negative inputs to zero when ReLU is enabled
  always_comb begin
    opnd = in_data;
    if (relu_q && in_data[IN_WIDTH-1]) begin
      opnd = '0;
    end
  end
`else
  logic unused_cfg_relu;
  assign unused_cfg_relu = cfg_relu;

  // No ReLU in this build: operand is the raw accumulator value
  always_comb begin
    opnd = in_data;
  end
`endif

  // S1 multiply at full product width (sign-extend both operands first)
  always_comb begin
    opnd_ext  = {{SCALE_WIDTH{opnd[IN_WIDTH-1]}}, opnd};
    scale_ext = {{IN_WIDTH{scale_q[SCALE_WIDTH-1]}}, scale_q};
    prod      = opnd_ext * scale_ext;
  end

  // S1 register: product plus the shift/zp that belong to this sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_shift <= '0;
      s1_zp    <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_prod  <= prod;
        s1_shift <= shift_q;
        s1_zp    <= zp_q;
      end
    end
  end

  // S2 round-half-up shift, zero-point add and saturation
  always_comb begin
    // Rounding constant is 1<<(shift-1); the trailing >>1 yields 0 for shift 0
    rnd     = ({{PW{1'b0}}, 1'b1} << s1_shift) >> 1;
    rsum    = $signed({s1_prod[PW-1], s1_prod}) + $signed(rnd);
    rshift  = rsum >>> s1_shift;
    v       = {rshift[PW], rshift} + {{(VW-OUT_WIDTH){s1_zp[OUT_WIDTH-1]}}, s1_zp};
    v_top   = v[VW-1:OUT_WIDTH-1];
    sat_val = v[OUT_WIDTH-1:0];
    if (!((&v_top) || (~|v_top))) begin
      sat_val = v[VW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                        : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  // S2 register: saturated int8 result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= sat_val;
      end
    end
  end

  // FIFO handshake decode; a pop frees a slot for a same-cycle push
  always_comb begin
    full = (count == FULL_CNT);
    pop  = out_valid && out_ready;
    push = s2_valid && (!full || pop);
    drop = s2_valid && full && !pop;
  end

  // FIFO storage; contents are only observable while count is non-zero
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s2_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set wins over clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Output view: head of FIFO, forced to zero when empty
  always_comb begin
    out_valid = (count != '0);
    out_data  = out_valid ? mem[rd_ptr] : '0;
    busy      = s1_valid || s2_valid || out_valid;
  end

endmodule
`default_nettype wire
